// File: rtl/mem_bus_arb_pkg.sv
// Shared types and defaults for the walker/CPU to system-RAM arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_bus_arb_pkg;

   localparam int DEF_ADDR_W         = 64;
   localparam int DEF_DATA_W         = 64;
   localparam int DEF_PTW_BURST_MAX  = 3;
   localparam int DEF_TIMEOUT_CYCLES = 255;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GNT_PTW = 2'd1,
      GNT_CPU = 2'd2,
      RESP    = 2'd3
   } arb_state_t;

   typedef enum logic {
      OWN_PTW = 1'b0,
      OWN_CPU = 1'b1
   } arb_owner_t;

endpackage

// File: rtl/mem_bus_arb_watchdog.sv
// Cycle watchdog for an outstanding RAM access; only exists when MEM_BUS_ARB_TIMEOUT_EN is defined.
// Latency: expire is combinational from the count, asserted in the TIMEOUT_CYCLES-th running cycle.
// Backpressure: none; start restarts the count, run advances it.
`ifdef MEM_BUS_ARB_TIMEOUT_EN
module mem_bus_arb_watchdog
   import mem_bus_arb_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   input  logic run,
   output logic expire
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] cnt;

   // Count running cycles from the last grant, parking on the final value.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (start) begin
         cnt <= '0;
      end else if (run && (cnt != LAST)) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign expire = run && (cnt == LAST);

endmodule
`endif

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the SV39 walker and CPU ports onto one RAM port, one access outstanding; optional watchdog via MEM_BUS_ARB_TIMEOUT_EN.
// Latency: walker pulse -> capture 1 -> grant 1 -> mem_ready (>=1) -> ready pulse 1 cycle later.
// Backpressure: walker pulses arriving while one is pending or in flight are dropped with arb_err; CPU holds its level request.
module mem_bus_arbiter
   import mem_bus_arb_pkg::*;
#(
   parameter int ADDR_W         = DEF_ADDR_W,
   parameter int DATA_W         = DEF_DATA_W,
   parameter int PTW_BURST_MAX  = DEF_PTW_BURST_MAX,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_W-1:0]     ptw_addr,
   input  logic                  ptw_read,
   output logic [DATA_W-1:0]     ptw_rdata,
   output logic                  ptw_ready,
   input  logic [ADDR_W-1:0]     cpu_addr,
   input  logic                  cpu_read,
   input  logic                  cpu_write,
   input  logic [DATA_W-1:0]     cpu_wdata,
   input  logic [DATA_W/8-1:0]   cpu_wstrb,
   output logic [DATA_W-1:0]     cpu_rdata,
   output logic                  cpu_ready,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic                  mem_read,
   output logic                  mem_write,
   output logic [DATA_W-1:0]     mem_wdata,
   output logic [DATA_W/8-1:0]   mem_wstrb,
   input  logic [DATA_W-1:0]     mem_rdata,
   input  logic                  mem_ready,
   output logic                  arb_err
);

   localparam int CNT_W = $clog2(PTW_BURST_MAX + 1);
   localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(PTW_BURST_MAX);

   // A zero limit would either lock the walker out or expire on every grant.
   if (PTW_BURST_MAX < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
      $error("mem_bus_arbiter: PTW_BURST_MAX and TIMEOUT_CYCLES must be >= 1");
   end

   arb_state_t        state, state_nxt;
   arb_owner_t        owner;
   logic              ptw_pend;
   logic [ADDR_W-1:0] ptw_addr_q;
   logic [CNT_W-1:0]  burst_cnt;
   logic              cpu_req, ptw_busy, ptw_take, ptw_drop;
   logic              grant_ptw, grant_cpu, xfer_end, timeout;
   logic [DATA_W-1:0] xfer_data;

   assign cpu_req  = cpu_read | cpu_write;
   assign ptw_busy = ptw_pend | (state == GNT_PTW);
   assign ptw_take = ptw_read & ~ptw_busy;
   assign ptw_drop = ptw_read & ptw_busy;

`ifdef MEM_BUS_ARB_TIMEOUT_EN
   logic wd_expire;

   mem_bus_arb_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk    (clk),
      .reset  (reset),
      .start  (grant_ptw | grant_cpu),
      .run    ((state == GNT_PTW) || (state == GNT_CPU)),
      .expire (wd_expire)
   );

   assign timeout = wd_expire & ~mem_ready;
`else
   assign timeout = 1'b0;
`endif

   // A timed-out access returns zero data to its owner.
   assign xfer_data = timeout ? '0 : mem_rdata;

   // Arbitration state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next state and grant/complete strobes. A walker pulse being captured in IDLE
   // holds off a CPU grant for that cycle so the walker wins the tie next cycle.
   always_comb begin
      state_nxt = state;
      grant_ptw = 1'b0;
      grant_cpu = 1'b0;
      xfer_end  = 1'b0;
      case (state)
         IDLE: begin
            if (ptw_pend && (!cpu_req || (burst_cnt < BURST_MAX))) begin
               grant_ptw = 1'b1;
               state_nxt = GNT_PTW;
            end else if (cpu_req && !ptw_take) begin
               grant_cpu = 1'b1;
               state_nxt = GNT_CPU;
            end
         end
         GNT_PTW, GNT_CPU: begin
            if (mem_ready || timeout) begin
               xfer_end  = 1'b1;
               state_nxt = RESP;
            end
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Latch one walker request; it stays pending until its access completes.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ptw_pend   <= 1'b0;
         ptw_addr_q <= '0;
      end else if (ptw_take) begin
         ptw_pend   <= 1'b1;
         ptw_addr_q <= ptw_addr;
      end else if (xfer_end && (owner == OWN_PTW)) begin
         ptw_pend   <= 1'b0;
      end
   end

   // Count walker grants that overtake a waiting CPU request.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         burst_cnt <= '0;
      end else if (!cpu_req || grant_cpu) begin
         burst_cnt <= '0;
      end else if (grant_ptw && (burst_cnt < BURST_MAX)) begin
         burst_cnt <= burst_cnt + 1'b1;
      end
   end

   // Load the RAM request registers on a grant; hold them until the access ends.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         owner     <= OWN_PTW;
         mem_addr  <= '0;
         mem_read  <= 1'b0;
         mem_write <= 1'b0;
         mem_wdata <= '0;
         mem_wstrb <= '0;
      end else if (grant_ptw) begin
         owner     <= OWN_PTW;
         mem_addr  <= ptw_addr_q;
         mem_read  <= 1'b1;
         mem_write <= 1'b0;
         mem_wdata <= '0;
         mem_wstrb <= '0;
      end else if (grant_cpu) begin
         owner     <= OWN_CPU;
         mem_addr  <= cpu_addr;
         mem_read  <= cpu_read & ~cpu_write;
         mem_write <= cpu_write;
         mem_wdata <= cpu_wdata;
         mem_wstrb <= cpu_wstrb;
      end else if (xfer_end) begin
         mem_read  <= 1'b0;
         mem_write <= 1'b0;
      end
   end

   // Register the owner's read data and raise its one-cycle ready in RESP.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ptw_rdata <= '0;
         cpu_rdata <= '0;
         ptw_ready <= 1'b0;
         cpu_ready <= 1'b0;
         arb_err   <= 1'b0;
      end else begin
         ptw_ready <= xfer_end && (owner == OWN_PTW);
         cpu_ready <= xfer_end && (owner == OWN_CPU);
         arb_err   <= ptw_drop | timeout;
         if (xfer_end) begin
            if (owner == OWN_PTW) ptw_rdata <= xfer_data;
            else                  cpu_rdata <= xfer_data;
         end
      end
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed-random bench for mem_bus_arbiter against a byte-strobed RAM model.
// Latency: expectations derived from the capture/grant/complete/respond cycle rules.
// Backpressure: RAM latency, stalls and spurious ready are controlled by the sequence.
module tb_mem_bus_arbiter;

`ifdef MEM_BUS_ARB_TIMEOUT_EN
   localparam int TB_TIMEOUT = 8;
`else
   localparam int TB_TIMEOUT = 255;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [63:0] ptw_addr = '0, cpu_addr = '0, cpu_wdata = '0, mem_rdata = '0;
   logic        ptw_read = 1'b0, cpu_read = 1'b0, cpu_write = 1'b0, mem_ready = 1'b0;
   logic [7:0]  cpu_wstrb = '0;
   logic [63:0] ptw_rdata, cpu_rdata, mem_addr, mem_wdata;
   logic [7:0]  mem_wstrb;
   logic        ptw_ready, cpu_ready, mem_read, mem_write, arb_err;

   int n_pass = 0, n_fail = 0, n_total = 0;
   int ptw_ready_cnt = 0, cpu_ready_cnt = 0, both_cnt = 0;

   always #5 clk = ~clk;

   mem_bus_arbiter #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
      .clk(clk), .reset(reset),
      .ptw_addr(ptw_addr), .ptw_read(ptw_read), .ptw_rdata(ptw_rdata), .ptw_ready(ptw_ready),
      .cpu_addr(cpu_addr), .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_wdata(cpu_wdata),
      .cpu_wstrb(cpu_wstrb), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
      .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write), .mem_wdata(mem_wdata),
      .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .arb_err(arb_err)
   );

   // ---------------- RAM reference: sparse memory with byte strobes ----------------
   logic [63:0] ram [logic [63:0]];
   logic [63:0] log_addr [$];
   int  ram_lat = 1;
   bit  ram_hold = 1'b0, ram_spurious = 1'b0;
   int  wait_cnt = 0;

   function automatic logic [63:0] seed_val(input logic [63:0] a);
      return {a[31:0] ^ 32'h5A5A_0F0F, a[63:32] + 32'h0000_1234};
   endfunction

   function automatic logic [63:0] mem_val(input logic [63:0] a);
      return ram.exists(a) ? ram[a] : seed_val(a);
   endfunction

   function automatic logic [63:0] rand_addr();
      return {32'h0000_0000, 1'b1, 28'($urandom), 3'b000};
   endfunction

   initial begin
      forever begin
         @(posedge clk); #2;
         mem_ready = 1'b0;
         if (reset && (mem_read || mem_write) && !ram_hold) begin
            if (wait_cnt >= ram_lat - 1) begin
               logic [63:0] v;
               mem_ready = 1'b1;
               wait_cnt  = 0;
               log_addr.push_back(mem_addr);
               v = mem_val(mem_addr);
               if (mem_write) begin
                  for (int b = 0; b < 8; b++) if (mem_wstrb[b]) v[b*8 +: 8] = mem_wdata[b*8 +: 8];
                  ram[mem_addr] = v;
               end else begin
                  mem_rdata = v;
               end
            end else begin
               wait_cnt++;
            end
         end else begin
            wait_cnt = 0;
            if (ram_spurious) begin
               mem_ready = 1'b1;
               mem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (ptw_ready === 1'b1) ptw_ready_cnt++;
      if (cpu_ready === 1'b1) cpu_ready_cnt++;
      if (ptw_ready === 1'b1 && cpu_ready === 1'b1) both_cnt++;
   end

   initial begin
      #500000;
      $display("FAIL tb_time_limit: simulation did not finish, passed %0d of %0d", n_pass, n_total);
      $fatal(1, "time limit");
   end

   // ---------------- helpers ----------------
   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_ready(input bit want_cpu, input int budget, output int cyc);
      cyc = 0;
      while (((want_cpu ? cpu_ready : ptw_ready) !== 1'b1) && (cyc < budget)) begin
         tick();
         cyc++;
      end
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      logic [63:0] a, b, wa, ca, old, wd;
      logic [63:0] waddr [5];
      logic [63:0] exp_q [6];
      int c, nw, np, cpu_done_at, pc0, cc0, n;

      repeat (3) tick();
      check("rst_mem_read",  mem_read,  0);
      check("rst_mem_write", mem_write, 0);
      check("rst_mem_addr",  mem_addr,  0);
      check("rst_ready",     {ptw_ready, cpu_ready, arb_err}, 0);
      check("rst_rdata",     ptw_rdata | cpu_rdata, 0);
      reset = 1'b1;
      tick();

      // Walker read, idle CPU, RAM answers in the 2nd request cycle.
      ram_lat = 2;
      a = 64'h8000_1008;
      ram[a] = 64'h2000_0401;
      ptw_addr = a; ptw_read = 1'b1;
      tick();
      ptw_read = 1'b0; ptw_addr = rand_addr();
      check("w1_no_bypass", mem_read, 0);
      tick();
      check("w1_mem_read", mem_read, 1);
      check("w1_mem_addr", mem_addr, a);
      check("w1_mem_wstrb", mem_wstrb, 0);
      wait_ready(1'b0, 20, c);
      check("w1_ready", ptw_ready, 1);
      check("w1_latency", c, 2);
      check("w1_rdata", ptw_rdata, 64'h2000_0401);
      check("w1_mem_read_drop", mem_read, 0);
      check("w1_cpu_quiet", cpu_ready, 0);
      tick();
      check("w1_ready_1cyc", ptw_ready, 0);

      // CPU store with partial strobes.
      ram_lat = 1;
      a = 64'h8000_2000;
      old = {$urandom, $urandom};
      ram[a] = old;
      pc0 = ptw_ready_cnt;
      cpu_addr = a; cpu_wdata = 64'hDEAD_BEEF; cpu_wstrb = 8'h0F; cpu_write = 1'b1;
      tick();
      check("st_mem_write", mem_write, 1);
      check("st_mem_read", mem_read, 0);
      check("st_mem_addr", mem_addr, a);
      check("st_mem_wdata", mem_wdata, 64'hDEAD_BEEF);
      check("st_mem_wstrb", mem_wstrb, 8'h0F);
      wait_ready(1'b1, 20, c);
      check("st_ready", cpu_ready, 1);
      cpu_write = 1'b0;
      tick();
      check("st_ram", ram[a], {old[63:32], 32'hDEAD_BEEF});
      check("st_ptw_quiet", ptw_ready_cnt - pc0, 0);

      // CPU load of the stored word.
      cpu_read = 1'b1;
      tick();
      check("ld_mem_read", mem_read, 1);
      wait_ready(1'b1, 20, c);
      check("ld_ready", cpu_ready, 1);
      check("ld_rdata", cpu_rdata, {old[63:32], 32'hDEAD_BEEF});
      cpu_read = 1'b0;
      tick();

      // Read and write together behave as a full-word write.
      b = rand_addr(); wd = {$urandom, $urandom};
      cpu_addr = b; cpu_wdata = wd; cpu_wstrb = 8'hFF; cpu_read = 1'b1; cpu_write = 1'b1;
      tick();
      check("rw_is_write", {mem_read, mem_write}, 2'b01);
      wait_ready(1'b1, 20, c);
      cpu_read = 1'b0; cpu_write = 1'b0;
      tick();
      check("rw_ram", ram[b], wd);

      // Contention: walker pulse and CPU read in the same cycle.
      log_addr.delete();
      ram_lat = $urandom_range(1, 3);
      wa = rand_addr(); ca = rand_addr();
      ptw_addr = wa; ptw_read = 1'b1; cpu_addr = ca; cpu_read = 1'b1;
      tick();
      ptw_read = 1'b0;
      check("ct_hold_off", mem_read, 0);
      tick();
      check("ct_walker_first", mem_addr, wa);
      wait_ready(1'b0, 20, c);
      check("ct_ptw_rdata", ptw_rdata, seed_val(wa));
      wait_ready(1'b1, 20, c);
      check("ct_cpu_ready", cpu_ready, 1);
      check("ct_cpu_rdata", cpu_rdata, seed_val(ca));
      cpu_read = 1'b0;
      check("ct_log_len", log_addr.size(), 2);
      if (log_addr.size() == 2) check("ct_order", log_addr[1], ca);
      tick();

      // Starvation limit: CPU read waits behind a stream of 5 walker reads.
      log_addr.delete();
      ram_lat = $urandom_range(1, 2);
      for (int i = 0; i < 5; i++) waddr[i] = rand_addr();
      ca = rand_addr();
      cpu_addr = ca; cpu_read = 1'b1;
      ptw_addr = waddr[0]; ptw_read = 1'b1;
      np = 1; nw = 0; cpu_done_at = -1;
      for (int cyc = 0; cyc < 300 && (nw < 5 || cpu_read); cyc++) begin
         tick();
         ptw_read = 1'b0;
         if (ptw_ready === 1'b1) begin
            check($sformatf("sv_w%0d_rdata", nw), ptw_rdata, seed_val(waddr[nw]));
            nw++;
            if (np < 5) begin
               ptw_addr = waddr[np]; ptw_read = 1'b1; np++;
            end
         end
         if (cpu_ready === 1'b1) begin
            cpu_done_at = nw;
            check("sv_cpu_rdata", cpu_rdata, seed_val(ca));
            cpu_read = 1'b0;
         end
      end
      check("sv_walker_done", nw, 5);
      check("sv_cpu_after_3", cpu_done_at, 3);
      tick();
      check("sv_burst_cleared", dut.burst_cnt, 0);
      exp_q = '{waddr[0], waddr[1], waddr[2], ca, waddr[3], waddr[4]};
      check("sv_log_len", log_addr.size(), 6);
      for (int i = 0; i < 6 && i < log_addr.size(); i++)
         check($sformatf("sv_order%0d", i), log_addr[i], exp_q[i]);

      // Dropped walker pulse while one is in flight.
      log_addr.delete();
      ram_lat = 4;
      wa = rand_addr();
      pc0 = ptw_ready_cnt;
      ptw_addr = wa; ptw_read = 1'b1;
      tick();
      ptw_read = 1'b0;
      tick();
      check("dr_in_flight", mem_read, 1);
      ptw_addr = rand_addr(); ptw_read = 1'b1;
      tick();
      ptw_read = 1'b0;
      check("dr_err", arb_err, 1);
      tick();
      check("dr_err_1cyc", arb_err, 0);
      repeat (12) tick();
      check("dr_one_access", log_addr.size(), 1);
      check("dr_one_ready", ptw_ready_cnt - pc0, 1);
      check("dr_rdata", ptw_rdata, seed_val(wa));

      // RAM ready while idle is ignored.
      pc0 = ptw_ready_cnt; cc0 = cpu_ready_cnt;
      ram_spurious = 1'b1;
      tick();
      ram_spurious = 1'b0;
      repeat (3) tick();
      check("sp_no_ready", (ptw_ready_cnt - pc0) + (cpu_ready_cnt - cc0), 0);
      check("sp_idle", {mem_read, mem_write, arb_err}, 0);

`ifdef MEM_BUS_ARB_TIMEOUT_EN
      // Watchdog: RAM never answers a CPU read.
      ram_hold = 1'b1;
      cpu_addr = rand_addr(); cpu_read = 1'b1;
      tick();
      n = 0;
      while (mem_read === 1'b1 && n < 50) begin
         tick();
         n++;
      end
      check("to_req_cycles", n, 8);
      check("to_cpu_ready", cpu_ready, 1);
      check("to_rdata_zero", cpu_rdata, 0);
      check("to_err", arb_err, 1);
      cpu_read = 1'b0; ram_hold = 1'b0;
      tick();
      check("to_err_1cyc", {arb_err, cpu_ready}, 0);
`endif

      // Reset in the middle of a stalled CPU access.
      ram_hold = 1'b1;
      cc0 = cpu_ready_cnt;
      cpu_addr = rand_addr(); cpu_read = 1'b1;
      repeat (6) tick();
      check("rm_still_waiting", mem_read, 1);
      check("rm_no_ready", cpu_ready_cnt - cc0, 0);
      reset = 1'b0;
      #1;
      check("rm_mem_read", mem_read, 0);
      check("rm_mem_addr", mem_addr, 0);
      check("rm_rdata", cpu_rdata, 0);
      cpu_read = 1'b0; ram_hold = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      ram_lat = 1;
      wa = rand_addr();
      ptw_addr = wa; ptw_read = 1'b1;
      tick();
      ptw_read = 1'b0;
      wait_ready(1'b0, 20, c);
      check("rm_after_ready", ptw_ready, 1);
      check("rm_after_rdata", ptw_rdata, seed_val(wa));
      tick();

      check("never_both_ready", both_cnt, 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
